fifo_wr_arbiter: RTL

Round-robin write-port arbiter that lets `NUM_REQ` producers share the single write port of the 128-bit FIFO. It grants one requester at a time for a bounded burst and drives the FIFO `i_wren`/`data_in` pins. It throttles on the FIFO `o_full`/`o_alm_full` flags and counts stall cycles. It sits between the producer agents and the FIFO write interface.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_t  : arbiter FSM states (IDLE between grants, GRANT while a
//                  requester owns the FIFO write port)
//   FIFO_DATA_W  : width of the FIFO data_in bus
//   STALL_W      : width of the saturating full-stall counter
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int FIFO_DATA_W = 128;
    localparam int STALL_W     = 16;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first set bit of 'req'
// searching upward from 'ptr', wrapping at NUM_REQ (NUM_REQ need not be a
// power of two).
// Ports:
//   req   in  NUM_REQ        request vector
//   ptr   in  $clog2(NUM_REQ) search start index (highest priority)
//   idx   out $clog2(NUM_REQ) index of the winner (0 when none)
//   found out 1              at least one request was set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       found
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] cand;

    // Walk the candidates in priority order starting at ptr; the explicit
    // wrap at LAST_IDX keeps non-power-of-two requester counts correct.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the single FIFO write port among NUM_REQ
// producers. One requester owns the port for a burst of up to MAX_BURST
// beats (1 beat while almost-full throttling is active); every grant is
// followed by one IDLE cycle. Writes are blocked while the FIFO is full and
// the blocked cycles are counted.
// Ports:
//   clk          in  1               clock, all state on rising edge
//   reset        in  1               asynchronous, active-low
//   i_req_valid  in  NUM_REQ         per-requester valid
//   i_req_data   in  NUM_REQ*DATA_W  requester r at [r*DATA_W +: DATA_W]
//   o_req_ready  out NUM_REQ         per-requester accept (at most one high)
//   o_grant      out NUM_REQ         one-hot current owner, 0 when idle
//   o_wren       out 1               FIFO i_wren
//   o_wrdata     out DATA_W          FIFO data_in
//   i_full       in  1               FIFO o_full
//   i_alm_full   in  1               FIFO o_alm_full
//   o_stall_cnt  out STALL_W         saturating count of full-blocked cycles
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = FIFO_DATA_W,
    parameter int MAX_BURST    = 8,
    parameter int ALM_THROTTLE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_wren,
    output logic [DATA_W-1:0]         o_wrdata,
    input  logic                      i_full,
    input  logic                      i_alm_full,
    output logic [STALL_W-1:0]        o_stall_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    arb_state_t          state, state_next;
    logic [IDX_W-1:0]    owner, owner_next;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_next;
    logic [CNT_W-1:0]    beat_cnt, beat_cnt_next;
    logic [STALL_W-1:0]  stall_cnt, stall_cnt_next;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic [NUM_REQ-1:0]  owner_onehot;
    logic [DATA_W-1:0]   owner_data;
    logic                owner_valid;
    logic [CNT_W-1:0]    limit;
    logic [CNT_W:0]      beat_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Decode the registered owner into a one-hot vector and select its data.
    always_comb begin
        owner_onehot = '0;
        owner_data   = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (owner == IDX_W'(r)) begin
                owner_onehot[r] = 1'b1;
                owner_data      = i_req_data[r*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_valid = i_req_valid[owner];
    assign limit       = ((ALM_THROTTLE != 0) && i_alm_full) ? CNT_W'(1) : BURST_LIMIT;
    assign beat_inc    = {1'b0, beat_cnt} + (CNT_W + 1)'(1);

    // Next-state and output logic. Full always wins over valid. The burst
    // end test uses >= so a throttle that appears mid-burst still closes the
    // grant on the next beat instead of letting beat_cnt run past the limit.
    always_comb begin
        state_next     = state;
        owner_next     = owner;
        rr_ptr_next    = rr_ptr;
        beat_cnt_next  = beat_cnt;
        stall_cnt_next = stall_cnt;
        o_grant        = '0;
        o_req_ready    = '0;
        o_wren         = 1'b0;
        o_wrdata       = '0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_next    = pick_idx;
                    beat_cnt_next = '0;
                    state_next    = GRANT;
                end
            end

            GRANT: begin
                o_grant  = owner_onehot;
                o_wrdata = owner_data;
                if (owner_valid && !i_full) begin
                    o_wren        = 1'b1;
                    o_req_ready   = owner_onehot;
                    beat_cnt_next = beat_inc[CNT_W-1:0];
                    if (beat_inc >= {1'b0, limit}) begin
                        state_next  = IDLE;
                        rr_ptr_next = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
                    end
                end else if (owner_valid) begin
                    if (stall_cnt != '1) begin
                        stall_cnt_next = stall_cnt + STALL_W'(1);
                    end
                end else begin
                    state_next  = IDLE;
                    rr_ptr_next = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers; reset returns arbitration to requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            rr_ptr    <= rr_ptr_next;
            beat_cnt  <= beat_cnt_next;
            stall_cnt <= stall_cnt_next;
        end
    end

    assign o_stall_cnt = stall_cnt;

endmodule
